alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//   Parametrised multi-cycle integer ALU for the rv32i core. Adds registered valid/ready
//   handshakes on operand input and result output, RV32 compare/shift ops, and iterative
//   unsigned multiply/divide. Sits between decode/operand-read and writeback; one op in flight.
// PARAMETERS
//   WIDTH     32   operand/result width (>=8, power of 2); SW = $clog2(WIDTH) shift-amount bits
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      reset, asynchronous, active-low
//   in_valid   in   1      operand/op presented
//   in_ready   out  1      block can accept op this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B (b[SW-1:0] = shift amount for shifts)
//   op         in   4      0 ADD,1 SUB,2 OR,3 AND,4 SLT,5 SLTU,6 XOR,7 SLL,8 SRL,9 SRA,
//                          10 MUL(low),11 MULHU,12 DIVU,13 REMU,14-15 reserved
//   out_valid  out  1      result/status/illegal valid
//   out_ready  in   1      consumer takes result
//   result     out  WIDTH  result
//   status     out  4      {n,z,c,v}
//   illegal    out  1      op was reserved/unsupported
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE; out_valid=0, result=0, status=0, illegal=0;
//     any in-flight op discarded; in_ready=1 on first cycle after release.
//   - FSM: IDLE -> (accept, ops 0-9/illegal) DONE; IDLE -> (accept, ops 10-13) BUSY;
//     BUSY -> DONE after WIDTH iteration cycles; DONE -> IDLE when out_ready.
//   - Accept = in_valid & in_ready. in_ready = IDLE | (DONE & out_ready) (back-to-back issue).
//   - Latency accept->out_valid: 1 cycle single ops; WIDTH+1 cycles for mul/div.
//   - out_valid=1 only in DONE; result/status/illegal held stable until out_ready.
//   - ADD: {c,result}=a+b; v=signed overflow. SUB: {c,result}={1'b0,a}-{1'b0,b}, c=1 on
//     borrow; v=(a,b signs differ) & (result sign != a sign). All other ops: c=0, v=0.
//   - SLT signed, SLTU unsigned: result = {WIDTH-1 zeros, cmp}. SRA sign-fills; SLL/SRL zero-fill.
//   - MUL: low WIDTH bits of a*b; MULHU: high WIDTH bits of unsigned 2*WIDTH product;
//     shift-add, one partial product per cycle.
//   - DIVU/REMU: restoring division, one quotient bit per cycle. b=0: DIVU result all ones,
//     REMU result = a (RISC-V semantics), still WIDTH+1 latency, illegal=0.
//   - n=result[WIDTH-1], z=(result==0) for every op including mul/div.
//   - Reserved op: accepted, 1-cycle, result=0, status=4'b0100, illegal=1.
//   - Operands captured at accept; a/b/op changes while BUSY have no effect.
// CONFIGURATION
//   ALU_MULDIV_EN defined: ops 10-13 implemented as above (iterative datapath present).
//   Not defined: no mul/div datapath, BUSY state unreachable; ops 10-13 behave as reserved
//   (1-cycle, result=0, status=4'b0100, illegal=1).
// TESTING
//   1. ADD a=32'h7FFF_FFFF b=1 -> next cycle out_valid, result 32'h8000_0000, status 4'b1001.
//   2. SUB a=5 b=5 -> result 0, status 4'b0100; SUB a=0 b=1 -> result all ones, status 4'b1010.
//   3. SRA a=32'h8000_0000 b=31 -> 32'hFFFF_FFFF; SLT a=-1 b=1 -> 1; SLTU same -> 0.
//   4. (ALU_MULDIV_EN) MULHU a=b=32'hFFFF_FFFF -> 32'hFFFF_FFFE after 33 cycles; DIVU 100/0 ->
//      32'hFFFF_FFFF, REMU 100/0 -> 100; in_ready low throughout BUSY.
//   5. Hold out_ready=0 5 cycles after ADD: result stable, in_ready=0; raise out_ready with next
//      in_valid -> same-cycle accept, new result next cycle (no bubble).
//   6. Assert rst_n=0 mid-DIVU -> out_valid=0 immediately; after release, new ADD 2+3 -> 5,
//      op 15 -> illegal=1, result 0.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer ALU with valid/ready handshakes on operands and result.
// Define ALU_MULDIV_EN to build the iterative shift-add multiply / restoring divide datapath.
module alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       status,
    output logic             illegal
);
    localparam int unsigned SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic [3:0]       r_status, w_status_nxt;
    logic             r_illegal, w_illegal_nxt;
    logic             w_accept;

    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_c, w_sc_v, w_sc_ill;
    logic [WIDTH:0]   w_add, w_sub;
    logic [SW-1:0]    w_shamt;

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign status    = r_status;
    assign illegal   = r_illegal;

    assign w_add   = {1'b0, a} + {1'b0, b};
    assign w_sub   = {1'b0, a} - {1'b0, b};
    assign w_shamt = b[SW-1:0];

    // Single-cycle operations; anything not listed is reported as illegal
    always_comb begin
        w_sc_res = '0;
        w_sc_c   = 1'b0;
        w_sc_v   = 1'b0;
        w_sc_ill = 1'b0;
        case (op)
            OP_ADD: begin
                w_sc_res = w_add[WIDTH-1:0];
                w_sc_c   = w_add[WIDTH];
                w_sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_res = w_sub[WIDTH-1:0];
                w_sc_c   = w_sub[WIDTH];
                w_sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:   w_sc_res = a | b;
            OP_AND:  w_sc_res = a & b;
            OP_XOR:  w_sc_res = a ^ b;
            OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  w_sc_res = a << w_shamt;
            OP_SRL:  w_sc_res = a >> w_shamt;
            OP_SRA:  w_sc_res = $unsigned($signed(a) >>> w_shamt);
            default: w_sc_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic [WIDTH-1:0] r_opnd, w_opnd_nxt;
    logic [WIDTH-1:0] r_hi, w_hi_nxt;
    logic [WIDTH-1:0] r_lo, w_lo_nxt;
    logic [SW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_div, w_div_nxt;
    logic             r_sel_hi, w_sel_hi_nxt;
    logic             w_is_md;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_sh;
    logic [WIDTH-1:0] w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_it_hi, w_it_lo, w_md_res;

    assign w_is_md = (op >= 4'd10) && (op <= 4'd13);

    // One iteration: shift-add step for multiply, restoring step for divide
    always_comb begin
        w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_div_sh   = {r_hi, r_lo[WIDTH-1]};
        w_div_ge   = (w_div_sh >= {1'b0, r_opnd});
        w_div_diff = w_div_sh[WIDTH-1:0] - r_opnd;
        if (r_div) begin
            w_it_hi = w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
            w_it_lo = {r_lo[WIDTH-2:0], w_div_ge};
        end else begin
            w_it_hi = w_mul_sum[WIDTH:1];
            w_it_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
        w_md_res = r_sel_hi ? w_it_hi : w_it_lo;
    end
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_result_nxt  = r_result;
        w_status_nxt  = r_status;
        w_illegal_nxt = r_illegal;
`ifdef ALU_MULDIV_EN
        w_opnd_nxt    = r_opnd;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_cnt_nxt     = r_cnt;
        w_div_nxt     = r_div;
        w_sel_hi_nxt  = r_sel_hi;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
`ifdef ALU_MULDIV_EN
                    // Ops 12/13 divide (bit 2 set); ops 11/13 return the high half
                    if (w_is_md) begin
                        w_state_nxt  = S_BUSY;
                        w_div_nxt    = op[2];
                        w_sel_hi_nxt = op[0];
                        w_opnd_nxt   = op[2] ? b : a;
                        w_lo_nxt     = op[2] ? a : b;
                        w_hi_nxt     = '0;
                        w_cnt_nxt    = SW'(WIDTH - 1);
                    end else
`endif
                    begin
                        w_state_nxt   = S_DONE;
                        w_result_nxt  = w_sc_res;
                        w_status_nxt  = {w_sc_res[WIDTH-1], (w_sc_res == '0), w_sc_c, w_sc_v};
                        w_illegal_nxt = w_sc_ill;
                    end
                end else if ((r_state == S_DONE) && out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef ALU_MULDIV_EN
            S_BUSY: begin
                w_hi_nxt  = w_it_hi;
                w_lo_nxt  = w_it_lo;
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt   = S_DONE;
                    w_result_nxt  = w_md_res;
                    w_status_nxt  = {w_md_res[WIDTH-1], (w_md_res == '0), 2'b00};
                    w_illegal_nxt = 1'b0;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_result  <= '0;
            r_status  <= '0;
            r_illegal <= 1'b0;
`ifdef ALU_MULDIV_EN
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_div     <= 1'b0;
            r_sel_hi  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_result  <= w_result_nxt;
            r_status  <= w_status_nxt;
            r_illegal <= w_illegal_nxt;
`ifdef ALU_MULDIV_EN
            r_opnd    <= w_opnd_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div     <= w_div_nxt;
            r_sel_hi  <= w_sel_hi_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed literal cases plus randomized traffic
// compared every cycle against an arithmetic reference model and a transaction queue.
module tb_alu_mc;
    localparam int W = 32;
`ifdef ALU_MULDIV_EN
    localparam int MD_LAT = W + 1;
`else
    localparam int MD_LAT = 1;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   status;
    logic         illegal;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .status    (status),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   st;
        logic         ill;
        int           lat;
        int           rdy;
    } txn_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    txn_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: what the ALU must return, from plain integer arithmetic
    function automatic txn_t model(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input int now);
        txn_t        t;
        logic        c, v;
        logic [63:0] ux, uy, p;
        longint      sx, sy;
        logic [4:0]  sh;
        ux = {32'b0, x};
        uy = {32'b0, y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = y[4:0];
        c = 1'b0;
        v = 1'b0;
        t.res = '0;
        t.ill = 1'b0;
        t.lat = 1;
        case (o)
            4'd0: begin
                t.res = x + y;
                c = ((ux + uy) >> W) != 64'd0;
                v = (sx + sy) != longint'($signed(t.res));
            end
            4'd1: begin
                t.res = x - y;
                c = x < y;
                v = (sx - sy) != longint'($signed(t.res));
            end
            4'd2: t.res = x | y;
            4'd3: t.res = x & y;
            4'd4: t.res = {31'b0, ($signed(x) < $signed(y))};
            4'd5: t.res = {31'b0, (x < y)};
            4'd6: t.res = x ^ y;
            4'd7: t.res = x << sh;
            4'd8: t.res = x >> sh;
            4'd9: t.res = $unsigned($signed(x) >>> sh);
`ifdef ALU_MULDIV_EN
            4'd10, 4'd11: begin
                p = ux * uy;
                t.res = (o == 4'd10) ? p[31:0] : p[63:32];
                t.lat = W + 1;
            end
            4'd12: begin
                t.res = (y == '0) ? '1 : x / y;
                t.lat = W + 1;
            end
            4'd13: begin
                t.res = (y == '0) ? x : x % y;
                t.lat = W + 1;
            end
`endif
            default: t.ill = 1'b1;
        endcase
        t.st  = {t.res[W-1], (t.res == '0), c, v};
        t.rdy = now + t.lat;
        return t;
    endfunction

    // Compare process: handshake, timing and payload checked on every falling edge
    always @(negedge clk) begin
        logic exp_ov, exp_ir;
        txn_t t;
        if (!rst_n) begin
            chk("rst_out_valid", W'(out_valid), W'(0));
            q.delete();
        end else begin
            if (q.size() == 0) begin
                exp_ov = 1'b0;
                exp_ir = 1'b1;
            end else if (cyc >= q[0].rdy) begin
                exp_ov = 1'b1;
                exp_ir = out_ready;
            end else begin
                exp_ov = 1'b0;
                exp_ir = 1'b0;
            end
            chk("out_valid", W'(out_valid), W'(exp_ov));
            chk("in_ready", W'(in_ready), W'(exp_ir));
            if (exp_ov && out_valid) begin
                chk("result", result, q[0].res);
                chk("status", W'(status), W'(q[0].st));
                chk("illegal", W'(illegal), W'(q[0].ill));
            end
            if (exp_ov && out_ready) void'(q.pop_front());
            if (in_valid && exp_ir) begin
                t = model(op, a, b, cyc);
                q.push_back(t);
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int t;
        t = 0;
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (t >= 100) chk("accept_timeout", W'(0), W'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic collect(input string nm, input logic [W-1:0] er, input logic [3:0] es,
                           input logic ei, input int elat, input logic rel);
        int n;
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({nm, "_lat"}, W'(n), W'(elat));
        chk({nm, "_res"}, result, er);
        chk({nm, "_st"}, W'(status), W'(es));
        chk({nm, "_ill"}, W'(illegal), W'(ei));
        if (rel) begin
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    task automatic dir(input string nm, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] er, input logic [3:0] es,
                       input logic ei, input int elat);
        out_ready = 1'b0;
        issue(o, x, y);
        collect(nm, er, es, ei, elat, 1'b1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return W'($urandom_range(0, 40));
            default: return W'($urandom());
        endcase
    endfunction

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", W'(in_ready), W'(1));
        chk("reset_result", result, W'(0));
        chk("reset_status", W'(status), W'(0));
        chk("reset_illegal", W'(illegal), W'(0));
        @(posedge clk);
        #1;

        dir("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001, 1'b0, 1);
        dir("sub_eq", 4'd1, 32'd5, 32'd5, 32'd0, 4'b0100, 1'b0, 1);
        dir("sub_borrow", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 4'b1010, 1'b0, 1);
        dir("sra", 4'd9, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 4'b1000, 1'b0, 1);
        dir("slt", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0000, 1'b0, 1);
        dir("sltu", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0100, 1'b0, 1);
`ifdef ALU_MULDIV_EN
        dir("mulhu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1000, 1'b0, MD_LAT);
        dir("divu0", 4'd12, 32'd100, 32'd0, 32'hFFFF_FFFF, 4'b1000, 1'b0, MD_LAT);
        dir("remu0", 4'd13, 32'd100, 32'd0, 32'd100, 4'b0000, 1'b0, MD_LAT);
        dir("mul", 4'd10, 32'd1234, 32'd5678, 32'd7006652, 4'b0000, 1'b0, MD_LAT);
        dir("divu", 4'd12, 32'd1000, 32'd7, 32'd142, 4'b0000, 1'b0, MD_LAT);
`else
        dir("mulhu_rsv", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4'b0100, 1'b1, MD_LAT);
        dir("divu_rsv", 4'd12, 32'd100, 32'd0, 32'd0, 4'b0100, 1'b1, MD_LAT);
`endif

        // Held result, then back-to-back issue in the release cycle
        out_ready = 1'b0;
        issue(4'd0, 32'd10, 32'd20);
        collect("hold", 32'd30, 4'b0000, 1'b0, 1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_res", result, 32'd30);
        chk("hold_in_ready", W'(in_ready), W'(0));
        out_ready = 1'b1;
        issue(4'd6, 32'hF0F0_F0F0, 32'hFFFF_0000);
        out_ready = 1'b0;
        collect("b2b", 32'h0F0F_F0F0, 4'b0000, 1'b0, 1, 1'b1);

        // Reset in the middle of an operation
        out_ready = 1'b0;
        issue(4'd12, 32'd1000, 32'd7);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", W'(out_valid), W'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        dir("post_rst_add", 4'd0, 32'd2, 32'd3, 32'd5, 4'b0000, 1'b0, 1);
        dir("op15", 4'd15, 32'd9, 32'd9, 32'd0, 4'b0100, 1'b1, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op        = 4'($urandom_range(0, 15));
            a         = pick();
            b         = pick();
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("drained_out_valid", W'(out_valid), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
